// File: rtl/fp_adder_pkg.sv
// Shared definitions for the floating-point adder back end: FSM states,
// field widths and the IEEE-754 single-precision field layout.
package fp_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int EXP_W = 8;
  localparam int MAN_W = 24;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Packed-result field positions.
  localparam int SIGN_POS = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;

  // Assemble {sign, exponent, fraction}. The hidden bit is not stored.
  function automatic logic [31:0] pack_word(input logic s,
                                            input logic [EXP_W-1:0] e,
                                            input logic [MAN_W-2:0] f);
    logic [31:0] w;
    w = '0;
    w[SIGN_POS]        = s;
    w[EXP_MSB:EXP_LSB] = e;
    w[FRAC_MSB:0]      = f;
    return w;
  endfunction

endpackage

// File: rtl/round_nearest_even.sv
// Combinational round-to-nearest-even for the carry right-shift, with
// renormalisation when the increment overflows the 24-bit mantissa.
// Only present when NORM_ROUND_EN is defined; the default build truncates.
`ifdef NORM_ROUND_EN
module round_nearest_even
  import fp_adder_pkg::*;
(
  input  logic [MAN_W-1:0] m_in,
  input  logic             dropped,
  output logic [MAN_W-1:0] m_out,
  output logic             renorm
);

  logic             inc;
  logic [MAN_W:0]   sum;

  // A single dropped bit set is always an exact half-way case, so the
  // increment happens only when the kept LSB is odd.
  always_comb begin
    inc    = dropped & m_in[0];
    sum    = {1'b0, m_in} + {{MAN_W{1'b0}}, inc};
    renorm = sum[MAN_W];
    m_out  = renorm ? {1'b1, {(MAN_W-1){1'b0}}} : sum[MAN_W-1:0];
  end

endmodule
`endif

// File: rtl/normalize_and_pack.sv
// Final stage of the fp32 adder: normalises the raw mantissa one bit per
// cycle, adjusts the exponent, packs an IEEE-754 word and flags
// overflow/underflow. Optional macro NORM_ROUND_EN enables round-to-nearest-
// even on the carry right-shift (default build truncates the dropped bit).
//
// Handshake: a job starts on a 0->1 transition of Stable_In (level input,
// registered into prev). Starts are accepted only in IDLE or DONE; a start
// seen in NORM is dropped. Result_valid is a level that stays high from job
// completion until the next accepted start or reset; Result only changes on
// the edge that completes a job.
module normalize_and_pack
  import fp_adder_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             S_In,
  input  logic [EXP_W-1:0] E_In,
  input  logic [MAN_W-1:0] M_In,
  input  logic             Carry_In,
  input  logic             Stable_In,
  output logic [31:0]      Result,
  output logic             Result_valid,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Busy,
  output logic [1:0]       state_dbg
);

  state_t           state, nx_state;
  logic             prev;
  logic             start;
  logic             s_r, nx_s;
  logic [EXP_W-1:0] e_r, nx_e;
  logic [MAN_W-1:0] m_r, nx_m;
  logic             c_r, nx_c;
  logic [31:0]      result_r, nx_result;
  logic             valid_r, nx_valid;
  logic             ovf_r, nx_ovf;
  logic             unf_r, nx_unf;

  logic [MAN_W-1:0] m_shift;
  logic [MAN_W-1:0] m_fin;
  logic             renorm;
  logic [EXP_W:0]   e_fin;

  assign start = Stable_In & ~prev;

  // Carry path: bring the carry in as the new hidden bit.
  assign m_shift = {1'b1, m_r[MAN_W-1:1]};

`ifdef NORM_ROUND_EN
  round_nearest_even u_round (
    .m_in    (m_shift),
    .dropped (m_r[0]),
    .m_out   (m_fin),
    .renorm  (renorm)
  );
`else
  assign m_fin  = m_shift;
  assign renorm = 1'b0;
`endif

  // One extra bit so a renormalise on top of E=255 still reads as overflow.
  assign e_fin = {1'b0, e_r} + 9'd1 + {8'd0, renorm};

  // Next-state and datapath: exactly one normalisation action per edge in NORM.
  always_comb begin
    nx_state  = state;
    nx_s      = s_r;
    nx_e      = e_r;
    nx_m      = m_r;
    nx_c      = c_r;
    nx_result = result_r;
    nx_valid  = valid_r;
    nx_ovf    = ovf_r;
    nx_unf    = unf_r;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          nx_s     = S_In;
          nx_e     = E_In;
          nx_m     = M_In;
          nx_c     = Carry_In;
          nx_valid = 1'b0;
          nx_ovf   = 1'b0;
          nx_unf   = 1'b0;
          nx_state = NORM;
        end
      end
      NORM: begin
        if (e_r == EXP_MAX) begin
          // NaN / infinity from upstream: pass through untouched.
          nx_result = pack_word(s_r, e_r, m_r[MAN_W-2:0]);
          nx_valid  = 1'b1;
          nx_state  = DONE;
        end else if (c_r) begin
          nx_m = m_fin;
          nx_e = e_fin[EXP_W-1:0];
          nx_c = 1'b0;
          if (e_fin >= {1'b0, EXP_MAX}) begin
            nx_result = pack_word(s_r, EXP_MAX, '0);
            nx_ovf    = 1'b1;
          end else begin
            nx_result = pack_word(s_r, e_fin[EXP_W-1:0], m_fin[MAN_W-2:0]);
          end
          nx_valid = 1'b1;
          nx_state = DONE;
        end else if (m_r == '0) begin
          // Exact cancellation always yields +0.
          nx_result = '0;
          nx_valid  = 1'b1;
          nx_state  = DONE;
        end else if (m_r[MAN_W-1]) begin
          nx_result = pack_word(s_r, e_r, m_r[MAN_W-2:0]);
          nx_valid  = 1'b1;
          nx_state  = DONE;
        end else if (e_r <= 8'd1) begin
          // No subnormal support: flush to signed zero.
          nx_result = pack_word(s_r, '0, '0);
          nx_unf    = 1'b1;
          nx_valid  = 1'b1;
          nx_state  = DONE;
        end else begin
          nx_m = {m_r[MAN_W-2:0], 1'b0};
          nx_e = e_r - 8'd1;
        end
      end
      default: nx_state = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      prev     <= 1'b0;
      s_r      <= 1'b0;
      e_r      <= '0;
      m_r      <= '0;
      c_r      <= 1'b0;
      result_r <= '0;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      state    <= nx_state;
      prev     <= Stable_In;
      s_r      <= nx_s;
      e_r      <= nx_e;
      m_r      <= nx_m;
      c_r      <= nx_c;
      result_r <= nx_result;
      valid_r  <= nx_valid;
      ovf_r    <= nx_ovf;
      unf_r    <= nx_unf;
    end
  end

  assign Result       = result_r;
  assign Result_valid = valid_r;
  assign Overflow     = ovf_r;
  assign Underflow    = unf_r;
  assign Busy         = (state == NORM);
  assign state_dbg    = state;

endmodule

// File: doc/normalize_and_pack.md
# normalize_and_pack

Final stage of the 32-bit floating-point adder. It sits directly downstream of the mantissa alignment/adder stage and consumes its sign, exponent, raw 24-bit mantissa, carry and stable flag. It normalises the mantissa iteratively, one bit per cycle, and adjusts the exponent. It then packs an IEEE-754 single-precision word and flags overflow and underflow.

## Interface
Parameters:
- none; widths are fixed at 8-bit exponent and 24-bit mantissa with the hidden bit included.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- S_In  in  1  sign from the adder stage.
- E_In  in  8  biased exponent from the adder stage.
- M_In  in  24  raw mantissa sum; bit 23 is the hidden-bit position.
- Carry_In  in  1  mantissa adder carry-out.
- Stable_In  in  1  adder result-stable level; a 0→1 transition starts a job.
- Result  out  32  packed word {S, E[7:0], M[22:0]}.
- Result_valid  out  1  level; high from job completion until the next start or reset.
- Overflow  out  1  result saturated to ±infinity.
- Underflow  out  1  result flushed to zero.
- Busy  out  1  high while a job is in progress.

## Operation
- Reset (Reset_n=0, asynchronous): state IDLE. Result=0, Result_valid=0, Overflow=0, Underflow=0, Busy=0. The previous-Stable_In register is cleared to 0.
- **Start detection:** Stable_In is registered into prev. Start = Stable_In & ~prev.
- **Start in IDLE or DONE:** capture S, E, M and Carry into working registers. Clear Result_valid, Overflow and Underflow. Go to NORM.
- **Start while in NORM:** ignored. prev still updates.
- **NORM, exactly one action per clock edge, in this priority:**
  1. E_In==255: pass S/E/M through unchanged → DONE.
  2. Carry=1: M={1,M[23:1]}, E=E+1, dropped bit = M[0]. Apply rounding (see Configuration). If the round overflows 24 bits, M=0x800000 and E increments again. If the final E==255: Result={S,8'hFF,23'b0}, Overflow=1 → DONE.
  3. M==0: Result=+0 (sign forced to 0) → DONE.
  4. M[23]=1: pack → DONE.
  5. M[23]=0 and E≤1: Result={S,31'b0}, Underflow=1 → DONE. Subnormals are not supported.
  6. Otherwise: M=M<<1, E=E−1, remain in NORM.
- **On entry to DONE:** Result is registered in the same edge and Result_valid=1. DONE waits for the next Start.
- Busy=1 exactly while the state is NORM.

## Timing
- Capture happens at edge T0, where Start is seen.
- Carry, zero, already-normalised, NaN/inf and overflow cases: Result_valid rises at T0+1.
- k leading zeros, no underflow: k shifts at T0+1..T0+k, done at T0+k+1. Worst case is 24 cycles.
- Underflow: done at T0+E_In, one edge after the last legal shift.
- Rounding and renormalise are combinational within the same cycle; they add no cycle.
- Reset mid-NORM aborts immediately; no partial Result is visible.
- Start coinciding with Reset_n low is ignored.

## Configuration
- NORM_ROUND_EN defined: the Carry right-shift rounds to nearest-even. Increment when dropped=1 and the new LSB=1. With exactly one dropped bit this is a half-way tie, so round-to-even applies.
- NORM_ROUND_EN undefined: the dropped bit is truncated and no renormalise path exists.

## Structure
- Shared package fp_adder_pkg holds:
  - state enum {IDLE, NORM, DONE};
  - EXP_W=8, MAN_W=24, EXP_MAX=8'hFF;
  - the packed-result field positions.
- One sub-module, round_nearest_even: combinational round plus renormalise. It is instantiated only under NORM_ROUND_EN.

## Test plan
- S=0, E=130, M=0x802000, C=0, Stable_In 0→1 → Result=0x41002000 at T0+1, no flags.
- S=1, E=120, M=0x000000, C=1 → Result=0xBC800000 at T0+1.
- S=1, E=120, M=0, C=0 (exact cancellation) → Result=0x00000000.
- S=0, E=100, M=0x000100, C=0 → 15 shifts, Result=0x2A800000, Result_valid at T0+16.
- E=254, M=0, C=1 → Result=0x7F800000, Overflow=1.
- E=10, M=0x000001 → Result=0, Underflow=1 at T0+10.
- E=100, M=0x000003, C=1 → Result=0x32800002 with NORM_ROUND_EN, 0x32800001 without.
